// File: rtl/alu_wb_pkg.sv
// Shared types and constants for the ALU writeback stage.
// Optional borrow-style carry flag is enabled with the ALU_WB_BORROW_EN macro.
package alu_wb_pkg;

   localparam int WB_DEPTH  = 2;
   localparam int WB_DATA_W = 8;
   localparam int WB_RD_W   = 2;

   localparam int FLAG_N = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_C = 0;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
   } flags_t;

   typedef struct packed {
      logic [WB_DATA_W-1:0] data;
      logic [WB_RD_W-1:0]   rd;
      flags_t               flags;
   } wb_entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational N/Z/C flag derivation for one ALU result.
// ALU_WB_BORROW_EN: when defined, subtract results report C as the inverted carry (borrow).
module alu_flag_gen
   import alu_wb_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] i_result,
   input  logic         i_carry,
   input  logic         i_op,
   output flags_t       o_flags
);

`ifdef ALU_WB_BORROW_EN
   localparam logic BORROW_EN = 1'b1;
`else
   localparam logic BORROW_EN = 1'b0;
`endif

   logic [2:0] w_bits;

   // Assemble flag bits at their architectural positions.
   always_comb begin
      w_bits         = 3'b000;
      w_bits[FLAG_N] = i_result[N-1];
      w_bits[FLAG_Z] = (i_result == {N{1'b0}});
      w_bits[FLAG_C] = i_carry ^ (i_op & BORROW_EN);
   end

   assign o_flags = flags_t'(w_bits);

endmodule

// File: rtl/alu_wb_stage.sv
// Writeback stage: 2-entry skid FIFO of ALU results with flags, plus architectural flags register.
// ALU_WB_BORROW_EN (see alu_flag_gen) changes only how C is derived.
module alu_wb_stage
   import alu_wb_pkg::*;
#(
   parameter int N    = 8,
   parameter int RD_W = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N-1:0]    in_result,
   input  logic            in_carry,
   input  logic            in_op,
   input  logic [RD_W-1:0] in_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N-1:0]    out_data,
   output logic [RD_W-1:0] out_rd,
   output flags_t          out_flags,
   output flags_t          flags_reg
);

   logic [N-1:0]    r_data  [WB_DEPTH];
   logic [RD_W-1:0] r_rd    [WB_DEPTH];
   flags_t          r_flags [WB_DEPTH];
   logic            r_head;
   logic            r_tail;
   logic [1:0]      r_count;
   flags_t          r_flags_reg;

   logic            w_push;
   logic            w_pop;
   flags_t          w_new_flags;

   alu_flag_gen #(.N(N)) u_flag_gen (
      .i_result (in_result),
      .i_carry  (in_carry),
      .i_op     (in_op),
      .o_flags  (w_new_flags)
   );

   // Handshake is decoded from registered count only, so out_ready never reaches in_ready.
   assign in_ready  = (r_count != 2'd2);
   assign out_valid = (r_count != 2'd0);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   assign out_data  = r_data[r_head];
   assign out_rd    = r_rd[r_head];
   assign out_flags = r_flags[r_head];
   assign flags_reg = r_flags_reg;

   // Buffer storage, pointers, occupancy and architectural flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < WB_DEPTH; i++) begin
            r_data[i]  <= {N{1'b0}};
            r_rd[i]    <= {RD_W{1'b0}};
            r_flags[i] <= flags_t'(3'b000);
         end
         r_head      <= 1'b0;
         r_tail      <= 1'b0;
         r_count     <= 2'd0;
         r_flags_reg <= flags_t'(3'b000);
      end else begin
         if (w_push) begin
            r_data[r_tail]  <= in_result;
            r_rd[r_tail]    <= in_rd;
            r_flags[r_tail] <= w_new_flags;
            r_tail          <= ~r_tail;
         end
         if (w_pop) begin
            r_head      <= ~r_head;
            r_flags_reg <= r_flags[r_head];
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: flag vector table, hand corner sequences, random traffic vs a queue model.
module tb_alu_wb_stage;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_result;
   logic       in_carry;
   logic       in_op;
   logic [1:0] in_rd;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [1:0] out_rd;
   logic [2:0] out_flags;
   logic [2:0] flags_reg;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] d;
      logic [1:0] rd;
      logic [2:0] f;
   } ent_t;

   typedef struct {
      logic [7:0] result;
      logic       carry;
      logic       op;
      logic [1:0] rd;
      logic [2:0] exp_flags;
   } vec_t;

   ent_t       q[$];
   logic [2:0] m_freg;

   alu_wb_stage #(.N(8), .RD_W(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_result (in_result),
      .in_carry  (in_carry),
      .in_op     (in_op),
      .in_rd     (in_rd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_rd    (out_rd),
      .out_flags (out_flags),
      .flags_reg (flags_reg)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected flags from the arithmetic meaning of the result.
   function automatic logic [2:0] ref_flags(input logic [7:0] d, input logic carry, input logic op);
      logic c;
`ifdef ALU_WB_BORROW_EN
      c = op ? !carry : carry;
`else
      c = carry;
`endif
      return {d >= 8'd128, d == 8'd0, c};
   endfunction

   // Check visible state against the model, then advance one clock and update the model.
   task automatic cycle();
      bit   do_push;
      bit   do_pop;
      ent_t e;
      chk("in_ready", in_ready, q.size() < 2);
      chk("out_valid", out_valid, q.size() != 0);
      chk("flags_reg", flags_reg, m_freg);
      if (q.size() != 0) begin
         chk("out_data", out_data, q[0].d);
         chk("out_rd", out_rd, q[0].rd);
         chk("out_flags", out_flags, q[0].f);
      end
      do_push = in_valid && (q.size() < 2);
      do_pop  = (q.size() != 0) && out_ready;
      e.d  = in_result;
      e.rd = in_rd;
      e.f  = ref_flags(in_result, in_carry, in_op);
      @(posedge clk);
      #1;
      if (do_pop) begin
         m_freg = q[0].f;
         void'(q.pop_front());
      end
      if (do_push) q.push_back(e);
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic c, input logic op,
                        input logic [1:0] rd, input logic ordy);
      in_valid  = v;
      in_result = d;
      in_carry  = c;
      in_op     = op;
      in_rd     = rd;
      out_ready = ordy;
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{8'h00, 1'b1, 1'b1, 2'd2, 3'b011};
      vecs[1] = '{8'h80, 1'b0, 1'b0, 2'd1, 3'b100};
      vecs[2] = '{8'h7F, 1'b1, 1'b0, 2'd3, 3'b001};
      vecs[3] = '{8'hFF, 1'b0, 1'b1, 2'd0, 3'b100};
      vecs[4] = '{8'h00, 1'b0, 1'b0, 2'd1, 3'b010};
      vecs[5] = '{8'h01, 1'b1, 1'b1, 2'd3, 3'b001};
`ifdef ALU_WB_BORROW_EN
      vecs[0].exp_flags = 3'b010;
      vecs[3].exp_flags = 3'b101;
      vecs[5].exp_flags = 3'b000;
`endif
      m_freg = 3'b000;
      drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
      reset = 1'b1;
      #1;
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_out_data", out_data, 8'h00);
      chk("reset_out_rd", out_rd, 2'd0);
      chk("reset_out_flags", out_flags, 3'b000);
      chk("reset_flags_reg", flags_reg, 3'b000);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Flag table: push one entry, inspect the head, then pop it into flags_reg.
      foreach (vecs[i]) begin
         drive(1'b1, vecs[i].result, vecs[i].carry, vecs[i].op, vecs[i].rd, 1'b0);
         cycle();
         drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
         chk("vec_out_valid", out_valid, 1'b1);
         chk("vec_out_data", out_data, vecs[i].result);
         chk("vec_out_rd", out_rd, vecs[i].rd);
         chk("vec_out_flags", out_flags, vecs[i].exp_flags);
         out_ready = 1'b1;
         cycle();
         chk("vec_flags_reg", flags_reg, vecs[i].exp_flags);
         chk("vec_drained", out_valid, 1'b0);
      end

      // Backpressure, ordering and full-with-out_ready-high.
      drive(1'b1, 8'h01, 1'b0, 1'b0, 2'd1, 1'b0);
      cycle();
      drive(1'b1, 8'h02, 1'b0, 1'b0, 2'd2, 1'b0);
      cycle();
      chk("bp_full_ready", in_ready, 1'b0);
      drive(1'b1, 8'h03, 1'b0, 1'b0, 2'd3, 1'b0);
      cycle();
      chk("bp_held_ready", in_ready, 1'b0);
      chk("bp_head_still_1", out_data, 8'h01);
      out_ready = 1'b1;
      cycle();
      chk("full_pop_head2", out_data, 8'h02);
      chk("full_pop_ready", in_ready, 1'b1);
      cycle();
      chk("order_head3", out_data, 8'h03);
      chk("order_rd3", out_rd, 2'd3);
      in_valid = 1'b0;
      cycle();
      chk("order_empty", out_valid, 1'b0);

      // Simultaneous push and pop with one entry buffered.
      drive(1'b1, 8'h05, 1'b0, 1'b0, 2'd1, 1'b0);
      cycle();
      drive(1'b1, 8'h06, 1'b1, 1'b0, 2'd2, 1'b1);
      cycle();
      chk("pp_head6", out_data, 8'h06);
      chk("pp_valid", out_valid, 1'b1);
      chk("pp_ready", in_ready, 1'b1);
      chk("pp_flags_reg", flags_reg, 3'b000);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);
      cycle();
      chk("pp_flags_reg6", flags_reg, 3'b001);

      // Reset mid-cycle with two entries buffered and non-zero flags_reg.
      drive(1'b1, 8'h80, 1'b0, 1'b0, 2'd0, 1'b1);
      cycle();
      cycle();
      drive(1'b1, 8'hAA, 1'b0, 1'b0, 2'd1, 1'b0);
      cycle();
      drive(1'b1, 8'h55, 1'b0, 1'b0, 2'd2, 1'b0);
      cycle();
      in_valid = 1'b0;
      chk("pre_reset_full", in_ready, 1'b0);
      chk("pre_reset_freg", flags_reg, 3'b100);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_reset_out_valid", out_valid, 1'b0);
      chk("mid_reset_in_ready", in_ready, 1'b1);
      chk("mid_reset_flags_reg", flags_reg, 3'b000);
      q.delete();
      m_freg = 3'b000;
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(1'b1, 8'h11, 1'b0, 1'b0, 2'd3, 1'b0);
      cycle();
      chk("post_reset_head", out_data, 8'h11);
      chk("post_reset_valid", out_valid, 1'b1);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);
      cycle();
      chk("post_reset_alone", out_valid, 1'b0);

      // Random traffic against the queue model.
      for (int k = 0; k < 400; k++) begin
         drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom), 1'($urandom),
               2'($urandom), ($urandom_range(0, 3) != 0));
         if ((k % 5) == 0) in_result = (k % 2 == 0) ? 8'h00 : 8'h80;
         cycle();
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);
      cycle();
      cycle();
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
